freq_div_prog: RTL and testbench
================================

# freq_div_prog

Runtime-programmable integer clock divider, the parametrised successor to the fixed even-only divider. It divides `clk` by any integer N ≥ 2 with 50% duty for both even and odd N; odd N uses a negedge retiming flop. The divisor can be changed at run time and takes effect glitch-free on a period boundary. The block also provides a clean start/stop enable and a per-period tick, and sits in the clock-generation area feeding divided clocks and strobes to downstream logic.

## Interface
- `CNT_W`, 8: width of the divisor and the period counter.
- `DEF_DIV`, 6: divisor active out of reset; must be ≥ 2 and < 2^CNT_W.
- `clk`  in  1  source clock; all flops are posedge except one negedge retiming flop.
- `rst_n`  in  1  asynchronous active-low reset.
- `en`  in  1  run request; start and stop are applied on period boundaries.
- `load`  in  1  one-cycle strobe: capture `div_val` as the pending divisor.
- `div_val`  in  CNT_W  new divisor; values 0 and 1 are clamped to 2 at capture.
- `clk_div`  out  1  divided clock.
- `tick`  out  1  one-cycle pulse marking the first source cycle of each divided period.
- `div_ack`  out  1  one-cycle pulse: the pending divisor became active.
- `busy`  out  1  high while in RUN or STOP.

## Operation
- State machine: IDLE, RUN, STOP.
- Registers:
  - `cnt` (CNT_W), active divisor N, pending divisor plus a valid flag.
  - `r_pos` (posedge) and `r_neg` (negedge copy of `r_pos`).
  - H = ceil(N/2).
- `clk_div` output:
  - N even: `clk_div = r_pos`.
  - N odd: `clk_div = r_pos & r_neg`, giving a high time of N/2 source periods.
- IDLE:
  - `cnt = 0`, `r_pos = 0`.
  - A valid pending divisor is applied at the next edge, with a `div_ack` pulse.
  - `en = 1` → RUN: `cnt <= 0`, `r_pos <= 1`, `tick <= 1`.
- RUN, at each posedge:
  - `nxt = (cnt == N-1) ? 0 : cnt + 1`.
  - `cnt <= nxt`, `r_pos <= (nxt < H)`, `tick <= (nxt == 0)`.
- Wrap (`cnt == N-1` in RUN):
  - If pending is valid: N <= pending, valid cleared, `div_ack <= 1`. H and `r_pos` for `nxt = 0` use the new N.
  - If `en = 0`: go to IDLE instead, `r_pos <= 0`, `tick <= 0`. The last period always completes at full length.
- STOP: entered when `en` falls mid-period. It behaves exactly like RUN until the wrap, then goes to IDLE. If `en` rises again before the wrap, the state returns to RUN with no disturbance.
- Load handling:
  - `load` in any state overwrites the pending divisor, last write wins.
  - If `load` coincides with a wrap, the old pending value is applied and the new value stays pending.
- Arithmetic:
  - `cnt` never exceeds N-1.
  - Comparisons are unsigned in CNT_W bits; `nxt < H` needs no width extension.
- Reset mid-operation forces every register to its reset value immediately, including the negedge flop. `clk_div` drops low asynchronously.

## Timing
- Reset values:
  - `clk_div = 0`, `tick = 0`, `div_ack = 0`, `busy = 0`.
  - State IDLE, `cnt = 0`, N = DEF_DIV, pending invalid.
- Start latency: `en` sampled high at posedge k → `clk_div` rises at edge k (even N) or at the following negedge (odd N). `tick` is high in cycle k to k+1.
- Period: exactly N source cycles between consecutive `tick` pulses. Even N gives high N/2 and low N/2. Odd N gives high and low of N/2 each, to half-cycle resolution.
- `div_ack` is asserted in the same cycle as the `tick` of the first period at the new N.
- Stop: `clk_div` is low and `busy` is 0 from the wrap edge after `en` falls. A runt pulse is never produced.
- There is no combinational path from any input to any output.

## Structure
- Shared package `freq_div_pkg`: state enum (IDLE, RUN, STOP), constant `MIN_DIV = 2`, clamp function for the divisor.
- One natural sub-module, `div_phase_gen`. It holds the counter, the H comparison and the `r_pos`/`r_neg` pair, takes N and a run qualifier, and produces `clk_div` and the wrap indication. The top level holds the FSM and the pending-divisor register.

## Test plan
- DEF_DIV = 6, `en = 1` → `clk_div` 3 high / 3 low, `tick` every 6 cycles, `busy = 1`.
- `load` with `div_val = 5` mid-period → current 6-cycle period completes, then `div_ack`. After that, `clk_div` high 2.5 and low 2.5 cycles (checked on both edges); `tick` every 5 cycles.
- `load` with `div_val = 1`, then `div_val = 0` → both clamp to 2, giving a 1/1 square wave after the boundary.
- `en` dropped 2 cycles into a period with N = 7 → the period finishes all 7 cycles, then `clk_div = 0` and `busy = 0`. `en` re-raised during STOP → no gap between periods.
- `load` of 4 on the exact wrap cycle while 8 is already pending → 8 applied with `div_ack`; 4 applied at the next wrap with a second `div_ack`.
- `rst_n` low for half a cycle while `clk_div` is high with odd N → all outputs 0 immediately. After release with `en = 1`, N = DEF_DIV and output resumes from `cnt = 0`.

Source files
------------

// File: rtl/freq_div_pkg.sv
// freq_div_pkg
//   Shared definitions for the programmable clock divider:
//   - state_t   : controller states (IDLE, RUN, STOP)
//   - MIN_DIV   : smallest divisor the divider will run with
//   - clamp_div : forces captured divisors below MIN_DIV up to MIN_DIV
package freq_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_t;

  localparam int unsigned MIN_DIV = 2;

  // Divisors 0 and 1 cannot produce a 50% clock, so they become MIN_DIV.
  function automatic logic [31:0] clamp_div(input logic [31:0] v);
    return (v < 32'(MIN_DIV)) ? 32'(MIN_DIV) : v;
  endfunction

endpackage

// File: rtl/freq_div_prog_if.sv
// freq_div_prog_if
//   Control/status bundle of the programmable clock divider.
//   master : drives en, load, div_val; observes clk_div, tick, div_ack, busy
//   slave  : the divider side of the same signals
interface freq_div_prog_if #(
  parameter int CNT_W = 8
) ();

  logic             en;       // run request, honoured on period boundaries
  logic             load;     // strobe: capture div_val as pending divisor
  logic [CNT_W-1:0] div_val;  // new divisor
  logic             clk_div;  // divided clock
  logic             tick;     // first source cycle of each divided period
  logic             div_ack;  // pending divisor became active
  logic             busy;     // running or finishing the last period

  modport master (
    output en, load, div_val,
    input  clk_div, tick, div_ack, busy
  );

  modport slave (
    input  en, load, div_val,
    output clk_div, tick, div_ack, busy
  );

endinterface

// File: rtl/div_phase_gen.sv
// div_phase_gen
//   Period counter and 50%-duty phase generator.
//   clk, rst_n : source clock, asynchronous active-low reset
//   i_n        : active divisor N (only changes at a wrap or while idle)
//   i_run      : keep counting through this edge
//   i_start    : begin a fresh period at this edge (counter at 0)
//   o_wrap     : counter is at N-1, this edge ends the period
//   o_clk_div  : divided clock
module div_phase_gen #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CNT_W-1:0] i_n,
  input  logic             i_run,
  input  logic             i_start,
  output logic             o_wrap,
  output logic             o_clk_div
);

  logic [CNT_W-1:0] r_cnt;
  logic             r_pos;
  logic             r_neg;
  logic [CNT_W-1:0] w_h;
  logic [CNT_W-1:0] w_nxt;

  // H = ceil(N/2); never exceeds 2^(CNT_W-1), so it fits in CNT_W bits.
  assign w_h    = (i_n >> 1) + {{(CNT_W-1){1'b0}}, i_n[0]};
  assign o_wrap = (r_cnt == (i_n - CNT_W'(1)));
  assign w_nxt  = o_wrap ? '0 : (r_cnt + CNT_W'(1));

  // At a wrap nxt is 0, and 0 < H holds for any N >= 2, so a divisor
  // swapped in on the same edge cannot change the r_pos decision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_pos <= 1'b0;
    end else if (i_run) begin
      r_cnt <= w_nxt;
      r_pos <= (w_nxt < w_h);
    end else begin
      r_cnt <= '0;
      r_pos <= i_start;
    end
  end

  // Half-cycle delayed copy of r_pos; ANDing it in for odd N trims the
  // high phase by half a source period, giving N/2 high and N/2 low.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_neg <= 1'b0;
    end else begin
      r_neg <= r_pos;
    end
  end

  // Both mux inputs are low at the wrap edge where i_n may change, so the
  // selection switch cannot glitch the output.
  assign o_clk_div = i_n[0] ? (r_pos & r_neg) : r_pos;

endmodule

// File: rtl/freq_div_prog.sv
// freq_div_prog
//   Runtime-programmable integer clock divider (N >= 2, 50% duty for even
//   and odd N) with period-aligned start/stop and divisor changes.
//   clk, rst_n : source clock, asynchronous active-low reset
//   bus        : slave side of freq_div_prog_if
//                (en, load, div_val in; clk_div, tick, div_ack, busy out)
module freq_div_prog
  import freq_div_pkg::*;
#(
  parameter int CNT_W   = 8,
  parameter int DEF_DIV = 6
) (
  input  logic           clk,
  input  logic           rst_n,
  freq_div_prog_if.slave bus
);

  state_t           r_state;
  logic [CNT_W-1:0] r_n;
  logic [CNT_W-1:0] r_pend;
  logic             r_pend_vld;
  logic             r_tick;
  logic             r_div_ack;
  logic             r_busy;

  logic             w_active;
  logic             w_wrap;
  logic             w_run;
  logic             w_start;
  logic             w_apply;
  logic             w_clk_div;
  logic [CNT_W-1:0] w_load_val;

  assign w_active   = (r_state != IDLE);
  // Keep counting unless this edge ends the period with en low.
  assign w_run      = w_active && !(w_wrap && !bus.en);
  assign w_start    = !w_active && bus.en;
  // A pending divisor goes live while idle or exactly on a period boundary.
  assign w_apply    = r_pend_vld && (!w_active || w_wrap);
  assign w_load_val = CNT_W'(clamp_div(32'(bus.div_val)));

  div_phase_gen #(
    .CNT_W(CNT_W)
  ) u_phase (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_n      (r_n),
    .i_run    (w_run),
    .i_start  (w_start),
    .o_wrap   (w_wrap),
    .o_clk_div(w_clk_div)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_n        <= CNT_W'(DEF_DIV);
      r_pend     <= '0;
      r_pend_vld <= 1'b0;
      r_tick     <= 1'b0;
      r_div_ack  <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      // nxt == 0 exactly when the counter wraps.
      r_tick    <= w_run ? w_wrap : w_start;
      r_div_ack <= w_apply;

      if (w_apply) begin
        r_n <= r_pend;
      end

      // A load on the apply edge replaces the value just consumed, so the
      // old pending divisor goes live and the new one stays pending.
      if (bus.load) begin
        r_pend     <= w_load_val;
        r_pend_vld <= 1'b1;
      end else if (w_apply) begin
        r_pend_vld <= 1'b0;
      end

      case (r_state)
        IDLE: begin
          if (bus.en) begin
            r_state <= RUN;
            r_busy  <= 1'b1;
          end
        end
        RUN, STOP: begin
          if (w_wrap && !bus.en) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_state <= bus.en ? RUN : STOP;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.clk_div = w_clk_div;
  assign bus.tick    = r_tick;
  assign bus.div_ack = r_div_ack;
  assign bus.busy    = r_busy;

endmodule

// File: tb/tb_freq_div_prog.sv
// tb_freq_div_prog
//   Directed and randomized stimulus for freq_div_prog, checked against a
//   period-level reference model: a running flag, the cycle index within the
//   current period, the active and pending divisors.
module tb_freq_div_prog;

  localparam int CNT_W   = 8;
  localparam int DEF_DIV = 6;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  freq_div_prog_if #(.CNT_W(CNT_W)) bus ();

  freq_div_prog #(
    .CNT_W  (CNT_W),
    .DEF_DIV(DEF_DIV)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit m_run;
  int m_pos;
  int m_n;
  int m_pend;
  bit m_pvld;
  bit exp_tick;
  bit exp_ack;

  task automatic check(input string tag, input logic obs, input logic expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b at %0t", tag, obs, expv, $time);
    end
  endtask

  // A period of N source cycles spans 2N half-cycles; the output is high for
  // exactly N of them. Even N is high in the first N halves, odd N starts
  // half a cycle late (first high half is index 1).
  function automatic logic exp_clk(input int half);
    int h;
    if (!m_run) return 1'b0;
    h = 2 * m_pos + half;
    if (m_n % 2 == 1) return (h >= 1 && h <= m_n);
    return (h < m_n);
  endfunction

  function automatic void model_reset();
    m_run    = 1'b0;
    m_pos    = 0;
    m_n      = DEF_DIV;
    m_pend   = 0;
    m_pvld   = 1'b0;
    exp_tick = 1'b0;
    exp_ack  = 1'b0;
  endfunction

  // Advance the model by one source cycle using the inputs sampled at the edge.
  function automatic void model_step(input bit e, input bit l, input int d);
    bit boundary;
    exp_ack  = 1'b0;
    boundary = 1'b0;
    if (m_run) begin
      m_pos++;
      if (m_pos == m_n) boundary = 1'b1;
    end else begin
      boundary = 1'b1;
    end
    if (boundary) begin
      if (m_pvld) begin
        m_n     = m_pend;
        m_pvld  = 1'b0;
        exp_ack = 1'b1;
      end
      m_run = e;
      m_pos = 0;
    end
    if (l) begin
      m_pend = (d < 2) ? 2 : d;
      m_pvld = 1'b1;
    end
    exp_tick = m_run && (m_pos == 0);
  endfunction

  task automatic cycle(input bit e, input bit l, input int d);
    bus.en      = e;
    bus.load    = l;
    bus.div_val = d[CNT_W-1:0];
    @(posedge clk);
    model_step(e, l, d);
    #1;
    check("clk_div_first_half", bus.clk_div, exp_clk(0));
    check("tick", bus.tick, exp_tick);
    check("div_ack", bus.div_ack, exp_ack);
    check("busy", bus.busy, m_run);
    @(negedge clk);
    #1;
    check("clk_div_second_half", bus.clk_div, exp_clk(1));
  endtask

  // Step with en held until the model reaches the given cycle of a running period.
  task automatic run_until(input int target, input bit e);
    int guard;
    guard = 0;
    while (!(m_run && m_pos == target) && guard < 64) begin
      cycle(e, 1'b0, 0);
      guard++;
    end
    check("run_until_bound", logic'(guard < 64), 1'b1);
  endtask

  initial begin
    bit re;
    bit rl;
    int rd;

    model_reset();
    bus.en      = 1'b0;
    bus.load    = 1'b0;
    bus.div_val = '0;

    // Reset state
    #1 rst_n = 1'b0;
    #1;
    check("rst_clk_div", bus.clk_div, 1'b0);
    check("rst_tick", bus.tick, 1'b0);
    check("rst_div_ack", bus.div_ack, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;

    // Idle with en low
    repeat (2) cycle(1'b0, 1'b0, 0);

    // Default divisor 6
    repeat (14) cycle(1'b1, 1'b0, 0);

    // Load 5 mid-period
    run_until(2, 1'b1);
    cycle(1'b1, 1'b1, 5);
    repeat (20) cycle(1'b1, 1'b0, 0);

    // Loads of 1 then 0 both clamp to 2
    run_until(1, 1'b1);
    cycle(1'b1, 1'b1, 1);
    cycle(1'b1, 1'b1, 0);
    repeat (10) cycle(1'b1, 1'b0, 0);

    // N = 7, en dropped two cycles into a period
    cycle(1'b1, 1'b1, 7);
    repeat (4) cycle(1'b1, 1'b0, 0);
    run_until(1, 1'b1);
    repeat (12) cycle(1'b0, 1'b0, 0);

    // Restart, then en dropped and re-raised before the wrap
    cycle(1'b1, 1'b0, 0);
    run_until(2, 1'b1);
    repeat (2) cycle(1'b0, 1'b0, 0);
    repeat (10) cycle(1'b1, 1'b0, 0);

    // 8 pending, 4 loaded on the exact wrap cycle
    run_until(2, 1'b1);
    cycle(1'b1, 1'b1, 8);
    run_until(m_n - 1, 1'b1);
    cycle(1'b1, 1'b1, 4);
    repeat (20) cycle(1'b1, 1'b0, 0);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      re = ($urandom_range(0, 9) != 0);
      rl = ($urandom_range(0, 7) == 0);
      rd = int'($urandom_range(0, 12));
      cycle(re, rl, rd);
    end

    // Reset while clk_div is high with odd N
    cycle(1'b1, 1'b1, 5);
    repeat (14) cycle(1'b1, 1'b0, 0);
    run_until(1, 1'b1);
    check("pre_reset_clk_div_high", bus.clk_div, 1'b1);
    rst_n = 1'b0;
    #1;
    model_reset();
    check("async_rst_clk_div", bus.clk_div, exp_clk(1));
    check("async_rst_tick", bus.tick, exp_tick);
    check("async_rst_div_ack", bus.div_ack, exp_ack);
    check("async_rst_busy", bus.busy, m_run);
    @(posedge clk);
    #1;
    check("rst_hold_clk_div", bus.clk_div, 1'b0);
    check("rst_hold_busy", bus.busy, 1'b0);
    rst_n = 1'b1;
    repeat (15) cycle(1'b1, 1'b0, 0);
    repeat (8) cycle(1'b0, 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
